exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 147 ++++++++++++++
 tb/tb_exception_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// Exception controller for the memory stage.
// Picks the highest-priority exception or interrupt and reports it to CP0.
// It then flushes the pipeline and hands the new fetch PC to the front end.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] pc_i,
  input  logic        delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [5:0]  interrupt_i,
  output logic [5:0]  interrupt_o,
  output logic [3:0]  exception_type_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic [31:0] current_pc_o,
  output logic        delayslot_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  localparam logic [3:0] EXC_TYPE_NONE = 4'd0;
  localparam logic [3:0] EXC_TYPE_INT  = 4'd1;
  localparam logic [3:0] EXC_TYPE_IF   = 4'd2;
  localparam logic [3:0] EXC_TYPE_RI   = 4'd3;
  localparam logic [3:0] EXC_TYPE_OV   = 4'd4;
  localparam logic [3:0] EXC_TYPE_BP   = 4'd5;
  localparam logic [3:0] EXC_TYPE_SYS  = 4'd6;
  localparam logic [3:0] EXC_TYPE_ADEL = 4'd7;
  localparam logic [3:0] EXC_TYPE_ADES = 4'd8;
  localparam logic [3:0] EXC_TYPE_ERET = 4'd9;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [5:0]  sync_meta;
  logic        int_pend;
  logic        accept;
  logic [3:0]  next_type;
  logic        unused_bits;

  // Only the IP/IM fields, IE and EXL of Status/Cause matter here.
  assign unused_bits = ^{status_i[31:16], status_i[9:2], cause_i[31:16], cause_i[9:0]};

  assign int_pend = (|(cause_i[15:10] & status_i[15:10])) & status_i[0] & ~status_i[1];
  assign accept   = (state == IDLE) && exc_valid_i && (int_pend || (|exc_flags_i));

  // Fixed-priority pick of the single event to take this cycle.
  always_comb begin
    next_type = EXC_TYPE_NONE;
    if (int_pend)            next_type = EXC_TYPE_INT;
    else if (exc_flags_i[0]) next_type = EXC_TYPE_IF;
    else if (exc_flags_i[1]) next_type = EXC_TYPE_RI;
    else if (exc_flags_i[2]) next_type = EXC_TYPE_OV;
    else if (exc_flags_i[3]) next_type = EXC_TYPE_BP;
    else if (exc_flags_i[4]) next_type = EXC_TYPE_SYS;
    else if (exc_flags_i[5]) next_type = EXC_TYPE_ADEL;
    else if (exc_flags_i[6]) next_type = EXC_TYPE_ADES;
    else if (exc_flags_i[7]) next_type = EXC_TYPE_ERET;
  end

  // Two-flop synchronizer for the asynchronous external interrupt lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta   <= '0;
      interrupt_o <= '0;
    end else begin
      sync_meta   <= interrupt_i;
      interrupt_o <= sync_meta;
    end
  end

  // Controller FSM: latch the event, hold flush, then wait for the redirect handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      flush_cnt        <= '0;
      exception_type_o <= EXC_TYPE_NONE;
      cp0_badvaddr_o   <= '0;
      current_pc_o     <= '0;
      delayslot_o      <= 1'b0;
      flush_o          <= 1'b0;
      busy_o           <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      exception_type_o <= EXC_TYPE_NONE;
      case (state)
        IDLE: begin
          if (accept) begin
            state            <= FLUSH;
            flush_cnt        <= FLUSH_LOAD;
            exception_type_o <= next_type;
            current_pc_o     <= pc_i;
            delayslot_o      <= delayslot_i;
            flush_o          <= 1'b1;
            busy_o           <= 1'b1;
            if (next_type == EXC_TYPE_IF)
              cp0_badvaddr_o <= pc_i;
            else if (next_type == EXC_TYPE_ADEL || next_type == EXC_TYPE_ADES)
              cp0_badvaddr_o <= mem_addr_i;
            redirect_pc_o    <= (next_type == EXC_TYPE_ERET) ? epc_i : EXC_VECTOR;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state            <= REDIRECT;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            state            <= IDLE;
            redirect_valid_o <= 1'b0;
            busy_o           <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          flush_o          <= 1'b0;
          busy_o           <= 1'b0;
          redirect_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with hand-computed expectations.
module tb_exception_ctrl;

  localparam logic [31:0] T_NONE = 32'd0;
  localparam logic [31:0] T_INT  = 32'd1;
  localparam logic [31:0] T_RI   = 32'd3;
  localparam logic [31:0] T_OV   = 32'd4;
  localparam logic [31:0] T_ADEL = 32'd7;
  localparam logic [31:0] T_ERET = 32'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_valid = 1'b0;
  logic [7:0]  exc_flags = '0;
  logic [31:0] pc = '0;
  logic        delayslot = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] status = '0;
  logic [31:0] cause = '0;
  logic [31:0] epc = '0;
  logic [5:0]  interrupt_in = '0;
  logic        redirect_ready = 1'b0;

  logic [5:0]  interrupt_out;
  logic [3:0]  exception_type;
  logic [31:0] cp0_badvaddr;
  logic [31:0] current_pc;
  logic        delayslot_out;
  logic        flush;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int check_count = 0;
  int pass_count  = 0;

  exception_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .exc_valid_i      (exc_valid),
    .exc_flags_i      (exc_flags),
    .pc_i             (pc),
    .delayslot_i      (delayslot),
    .mem_addr_i       (mem_addr),
    .status_i         (status),
    .cause_i          (cause),
    .epc_i            (epc),
    .interrupt_i      (interrupt_in),
    .interrupt_o      (interrupt_out),
    .exception_type_o (exception_type),
    .cp0_badvaddr_o   (cp0_badvaddr),
    .current_pc_o     (current_pc),
    .delayslot_o      (delayslot_out),
    .flush_o          (flush),
    .busy_o           (busy),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .redirect_ready_i (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    else
      pass_count++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] flags, input logic [31:0] pc_v,
                               input logic ds, input logic [31:0] addr);
    exc_valid = valid;
    exc_flags = flags;
    pc        = pc_v;
    delayslot = ds;
    mem_addr  = addr;
  endtask

  task automatic finishEvent(input string tag);
    for (int i = 0; i < 20 && !redirect_valid; i++) tick();
    checkOutput({tag, "_redir_reached"}, {31'd0, redirect_valid}, 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checkOutput({tag, "_back_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #3;
    checkOutput("rst_type",     {28'd0, exception_type}, T_NONE);
    checkOutput("rst_flush",    {31'd0, flush}, 32'd0);
    checkOutput("rst_rvalid",   {31'd0, redirect_valid}, 32'd0);
    checkOutput("rst_busy",     {31'd0, busy}, 32'd0);
    checkOutput("rst_rpc",      redirect_pc, 32'd0);
    checkOutput("rst_badvaddr", cp0_badvaddr, 32'd0);
    checkOutput("rst_curpc",    current_pc, 32'd0);
    checkOutput("rst_int",      {26'd0, interrupt_out}, 32'd0);
    tick();
    rst = 1'b1;

    // OV, accepted on the very first edge after reset release
    applyStimulus(1'b1, 8'h04, 32'h80001000, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
    checkOutput("ov_type",   {28'd0, exception_type}, T_OV);
    checkOutput("ov_flush1", {31'd0, flush}, 32'd1);
    checkOutput("ov_busy",   {31'd0, busy}, 32'd1);
    checkOutput("ov_curpc",  current_pc, 32'h80001000);
    checkOutput("ov_ds",     {31'd0, delayslot_out}, 32'd0);
    checkOutput("ov_rv_n1",  {31'd0, redirect_valid}, 32'd0);
    tick();
    checkOutput("ov_type_n2", {28'd0, exception_type}, T_NONE);
    checkOutput("ov_flush2",  {31'd0, flush}, 32'd1);
    tick();
    checkOutput("ov_flush3",  {31'd0, flush}, 32'd0);
    checkOutput("ov_rvalid",  {31'd0, redirect_valid}, 32'd1);
    checkOutput("ov_rpc",     redirect_pc, 32'hBFC00380);
    tick();
    checkOutput("ov_hold_rv", {31'd0, redirect_valid}, 32'd1);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checkOutput("ov_rv_done", {31'd0, redirect_valid}, 32'd0);
    checkOutput("ov_idle",    {31'd0, busy}, 32'd0);

    // ADEL beats ADES, bad address comes from the data address
    applyStimulus(1'b1, 8'h60, 32'h80003000, 1'b1, 32'h80002003);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
    checkOutput("adel_type", {28'd0, exception_type}, T_ADEL);
    checkOutput("adel_bad",  cp0_badvaddr, 32'h80002003);
    checkOutput("adel_ds",   {31'd0, delayslot_out}, 32'd1);
    finishEvent("adel");

    // Interrupt synchronizer latency, then INT taken ahead of RI
    status       = 32'h0000FF01;
    interrupt_in = 6'h01;
    tick();
    checkOutput("sync_lat1", {26'd0, interrupt_out}, 32'd0);
    tick();
    checkOutput("sync_lat2", {26'd0, interrupt_out}, 32'd1);
    cause = 32'h00000400;
    applyStimulus(1'b1, 8'h02, 32'h80004000, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
    checkOutput("int_type", {28'd0, exception_type}, T_INT);
    checkOutput("int_bad_keep", cp0_badvaddr, 32'h80002003);
    finishEvent("int");

    // RI alone; bad address must stay unchanged
    status = 32'h0;
    cause  = 32'h0;
    applyStimulus(1'b1, 8'h02, 32'h80005000, 1'b0, 32'h12345678);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
    checkOutput("ri_type", {28'd0, exception_type}, T_RI);
    checkOutput("ri_bad_keep", cp0_badvaddr, 32'h80002003);
    finishEvent("ri");

    // EXL set with a pending interrupt and no flags: nothing happens
    status = 32'h0000FF03;
    cause  = 32'h00000400;
    applyStimulus(1'b1, 8'h00, 32'h80006000, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("exl_busy", {31'd0, busy}, 32'd0);
      checkOutput("exl_type", {28'd0, exception_type}, T_NONE);
    end
    status = 32'h0;
    cause  = 32'h0;
    interrupt_in = 6'h00;

    // ERET with a stalled redirect and a second event waiting upstream
    epc = 32'h80000010;
    applyStimulus(1'b1, 8'h80, 32'h80007000, 1'b0, 32'h0);
    tick();
    checkOutput("eret_type", {28'd0, exception_type}, T_ERET);
    epc = 32'h89ABCDEF;
    applyStimulus(1'b1, 8'h04, 32'h80008000, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("eret_rvalid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("eret_rpc",    redirect_pc, 32'h80000010);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("eret_stall_rv",   {31'd0, redirect_valid}, 32'd1);
      checkOutput("eret_stall_busy", {31'd0, busy}, 32'd1);
      checkOutput("eret_stall_type", {28'd0, exception_type}, T_NONE);
      checkOutput("eret_stall_rpc",  redirect_pc, 32'h80000010);
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checkOutput("hs_drop_type", {28'd0, exception_type}, T_NONE);
    checkOutput("hs_busy",      {31'd0, busy}, 32'd0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
    checkOutput("next_accept_type", {28'd0, exception_type}, T_OV);
    checkOutput("next_accept_pc",   current_pc, 32'h80008000);
    checkOutput("next_flush",       {31'd0, flush}, 32'd1);

    // Asynchronous reset in the middle of FLUSH
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_flush", {31'd0, flush}, 32'd0);
    checkOutput("arst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("arst_type",  {28'd0, exception_type}, T_NONE);
    checkOutput("arst_curpc", current_pc, 32'd0);
    checkOutput("arst_bad",   cp0_badvaddr, 32'd0);
    checkOutput("arst_rpc",   redirect_pc, 32'd0);
    tick();
    checkOutput("arst_held_flush", {31'd0, flush}, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
